// File: rtl/pipeline_sequencer.sv
// Instruction-history stage between fetch and decode: load-use bubbles, branch squash, HALT park.
// One-cycle latency fetch->command; fetch_ready is combinational and drops only on load-use or HALT.
module pipeline_sequencer #(
    parameter logic [15:0] NOP_WORD    = 16'hC0E0,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter logic [3:0]  HALT_OP     = 4'b1111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [15:0] fetch_word,
    output logic        fetch_ready,
    input  logic        branch_taken,
    input  logic        resume,
    output logic [15:0] command,
    output logic [15:0] before_command,
    output logic [15:0] two_before_cmd,
    output logic        issue_valid,
    output logic        halted,
    output logic [15:0] stall_count
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);

    state_t      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] command_q, before_q, two_before_q;
    logic        issue_valid_q;

    logic [15:0] next_cmd;
    logic        squash;
    logic        accept;
    logic        hazard;
    logic        is_halt;
    logic [2:0]  ld_dest;

    // A load in command conflicts with a reader of its destination on fetch.
    assign ld_dest = command_q[13:11];
    assign hazard  = (command_q[15:14] == 2'b00) && fetch_valid &&
                     (((fetch_word[15:14] != 2'b10) && (fetch_word[10:8]  == ld_dest)) ||
                      ((fetch_word[15:14] == 2'b11) && (fetch_word[13:11] == ld_dest)));
    assign is_halt = (fetch_word[15:14] == 2'b11) && (fetch_word[7:4] == HALT_OP);

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        stall_count_d = stall_count_q;
        fetch_ready   = 1'b0;
        squash        = 1'b0;
        accept        = 1'b0;
        case (state_q)
            ST_RUN: begin
                squash = branch_taken || (flush_cnt_q != 3'd0);
                if (branch_taken) begin
                    flush_cnt_d = FLUSH_RELOAD;
                end else if (flush_cnt_q != 3'd0) begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
                if (squash) begin
                    // Wrong-path words are consumed so fetch can move past them.
                    fetch_ready = 1'b1;
                end else if (hazard) begin
                    fetch_ready = 1'b0;
                    if (stall_count_q != 16'hFFFF) begin
                        stall_count_d = stall_count_q + 16'd1;
                    end
                end else begin
                    fetch_ready = 1'b1;
                    accept      = fetch_valid;
                end
                if (accept && is_halt) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                flush_cnt_d = 3'd0;
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        next_cmd = accept ? fetch_word : NOP_WORD;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= 3'd0;
            stall_count_q <= 16'd0;
            command_q     <= NOP_WORD;
            before_q      <= NOP_WORD;
            two_before_q  <= NOP_WORD;
            issue_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            stall_count_q <= stall_count_d;
            two_before_q  <= before_q;
            before_q      <= command_q;
            command_q     <= next_cmd;
            issue_valid_q <= accept;
        end
    end

    assign command        = command_q;
    assign before_command = before_q;
    assign two_before_cmd = two_before_q;
    assign issue_valid    = issue_valid_q;
    assign halted         = (state_q == ST_HALT);
    assign stall_count    = stall_count_q;

endmodule
